// File: rtl/sum_sign_normalize_if.sv
// Handshake bundle between the mantissa adder, the sign/normalize stage and the result packer.
// The slave modport is the normalizer's view; the master modport is the surrounding datapath's view.
interface sum_sign_normalize_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              inValid;
    logic              inReady;
    logic [MANT_W:0]   sumIn;
    logic              subtract;
    logic              signIn;
    logic [EXP_W-1:0]  exponentIn;
    logic              outValid;
    logic              outReady;
    logic              signOut;
    logic [MANT_W-1:0] mantissaOut;
    logic [EXP_W-1:0]  exponentOut;
    logic              zeroOut;
    logic              underflowOut;
    logic              overflowOut;

    modport slave (
        input  inValid, sumIn, subtract, signIn, exponentIn, outReady,
        output inReady, outValid, signOut, mantissaOut, exponentOut,
               zeroOut, underflowOut, overflowOut
    );

    modport master (
        output inValid, sumIn, subtract, signIn, exponentIn, outReady,
        input  inReady, outValid, signOut, mantissaOut, exponentOut,
               zeroOut, underflowOut, overflowOut
    );
endinterface

// File: rtl/sum_sign_normalize.sv
// Floating-point adder back end: sign-magnitude recovery and one-shift-per-cycle normalization.
// Define ROUND_EN to round the carry right-shift to nearest-even instead of truncating.
module sum_sign_normalize #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sum_sign_normalize_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CHECK, NORM, DONE} state_t;

    localparam logic [MANT_W:0]  MAG_ONE = {{MANT_W{1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    state_t           stateReg, stateNext;
    logic [MANT_W:0]  magReg, magNext;
    logic [EXP_W-1:0] expReg, expNext;
    logic             signReg, signNext;
    logic             zeroReg, zeroNext;
    logic             underReg, underNext;
    logic             overReg, overNext;

    logic [MANT_W:0]  shiftedMag;
    logic [EXP_W-1:0] expInc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
            magReg   <= '0;
            expReg   <= '0;
            signReg  <= 1'b0;
            zeroReg  <= 1'b0;
            underReg <= 1'b0;
            overReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            magReg   <= magNext;
            expReg   <= expNext;
            signReg  <= signNext;
            zeroReg  <= zeroNext;
            underReg <= underNext;
            overReg  <= overNext;
        end
    end

    // Carry right-shift; with rounding, a tie rounds up only when the kept LSB is odd.
    always_comb begin
        shiftedMag = {1'b0, magReg[MANT_W:1]};
`ifdef ROUND_EN
        if (magReg[0] && magReg[1]) begin
            shiftedMag = shiftedMag + MAG_ONE;
        end
`endif
        expInc = expReg + EXP_ONE;
    end

    always_comb begin
        stateNext = stateReg;
        magNext   = magReg;
        expNext   = expReg;
        signNext  = signReg;
        zeroNext  = zeroReg;
        underNext = underReg;
        overNext  = overReg;

        case (stateReg)
            IDLE: begin
                if (bus.inValid) begin
                    zeroNext  = 1'b0;
                    underNext = 1'b0;
                    overNext  = 1'b0;
                    expNext   = bus.exponentIn;
                    if (bus.subtract && bus.sumIn[MANT_W]) begin
                        magNext  = (~bus.sumIn) + MAG_ONE;
                        signNext = 1'b1;
                    end else begin
                        magNext  = bus.sumIn;
                        signNext = bus.subtract ? 1'b0 : bus.signIn;
                    end
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                if (expReg == EXP_MAX) begin
                    overNext  = 1'b1;
                    magNext   = '0;
                    stateNext = DONE;
                end else if (magReg == '0) begin
                    zeroNext  = 1'b1;
                    signNext  = 1'b0;
                    expNext   = '0;
                    stateNext = DONE;
                end else if (magReg[MANT_W]) begin
                    expNext = expInc;
                    if (expInc == EXP_MAX) begin
                        overNext  = 1'b1;
                        magNext   = '0;
                        stateNext = DONE;
                    end else begin
                        magNext = shiftedMag;
                        // A rounding carry needs one more pass through the carry check.
                        stateNext = shiftedMag[MANT_W] ? CHECK : DONE;
                    end
                end else if (magReg[MANT_W-1]) begin
                    stateNext = DONE;
                end else begin
                    stateNext = NORM;
                end
            end
            NORM: begin
                if (magReg[MANT_W-1]) begin
                    stateNext = DONE;
                end else if (expReg == '0) begin
                    underNext = 1'b1;
                    stateNext = DONE;
                end else begin
                    magNext = {magReg[MANT_W-1:0], 1'b0};
                    expNext = expReg - EXP_ONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.inReady      = (stateReg == IDLE);
    assign bus.outValid     = (stateReg == DONE);
    assign bus.signOut      = signReg;
    assign bus.mantissaOut  = magReg[MANT_W-1:0];
    assign bus.exponentOut  = expReg;
    assign bus.zeroOut      = zeroReg;
    assign bus.underflowOut = underReg;
    assign bus.overflowOut  = overReg;
endmodule

// File: tb/tb_sum_sign_normalize.sv
// Directed bench for sum_sign_normalize: each operation checks latency, result fields and handshake.
// Expectations for the carry-rounding case follow ROUND_EN.
module tb_sum_sign_normalize;
    logic clk;
    logic rst_n;
    int   passCnt;
    int   totalCnt;

    sum_sign_normalize_if #(.MANT_W(24), .EXP_W(8)) bus ();

    sum_sign_normalize #(.MANT_W(24), .EXP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic runOp(input string name, input logic [24:0] sum, input logic sub,
                         input logic sgn, input logic [7:0] expIn, input int expLat,
                         input logic expSign, input logic [23:0] expMant, input logic [7:0] expExp,
                         input logic expZero, input logic expUnder, input logic expOver,
                         input int holdCycles);
        int lat;
        @(negedge clk);
        check({name, " inReady before accept"}, 32'(bus.inReady), 32'd1);
        bus.sumIn      = sum;
        bus.subtract   = sub;
        bus.signIn     = sgn;
        bus.exponentIn = expIn;
        bus.inValid    = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        lat = 1;
        while (bus.outValid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(expLat));
        check({name, " signOut"}, 32'(bus.signOut), 32'(expSign));
        check({name, " mantissaOut"}, 32'(bus.mantissaOut), 32'(expMant));
        check({name, " exponentOut"}, 32'(bus.exponentOut), 32'(expExp));
        check({name, " flags z/u/o"},
              32'({bus.zeroOut, bus.underflowOut, bus.overflowOut}),
              32'({expZero, expUnder, expOver}));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold outValid/inReady"}, 32'({bus.outValid, bus.inReady}), 32'b10);
            check({name, " hold mantissaOut"}, 32'(bus.mantissaOut), 32'(expMant));
            check({name, " hold exponentOut"}, 32'(bus.exponentOut), 32'(expExp));
        end
        @(negedge clk);
        bus.outReady = 1'b1;
        @(posedge clk);
        #1;
        bus.outReady = 1'b0;
        check({name, " after handshake outValid/inReady"},
              32'({bus.outValid, bus.inReady}), 32'b01);
        $display("op %s: sum=%h sub=%0d exp=%0d -> sign=%0d mant=%h exp=%0d lat=%0d",
                 name, sum, sub, expIn, expSign, expMant, expExp, lat);
    endtask

    initial begin
        passCnt        = 0;
        totalCnt       = 0;
        rst_n          = 1'b0;
        bus.inValid    = 1'b0;
        bus.sumIn      = '0;
        bus.subtract   = 1'b0;
        bus.signIn     = 1'b0;
        bus.exponentIn = '0;
        bus.outReady   = 1'b0;

        #12;
        check("reset inReady/outValid", 32'({bus.inReady, bus.outValid}), 32'b10);
        check("reset result fields",
              32'({bus.signOut, bus.mantissaOut, bus.exponentOut}), 32'd0);
        check("reset flags",
              32'({bus.zeroOut, bus.underflowOut, bus.overflowOut}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("normalized",   25'h0800000, 1'b0, 1'b1, 8'd127, 2, 1'b1, 24'h800000, 8'd127, 0, 0, 0, 0);
        runOp("carry",        25'h1000000, 1'b0, 1'b0, 8'd127, 2, 1'b0, 24'h800000, 8'd128, 0, 0, 0, 0);
        runOp("carry_ovf",    25'h1000000, 1'b0, 1'b0, 8'd254, 2, 1'b0, 24'h000000, 8'd255, 0, 0, 1, 0);
        runOp("exp_allones",  25'h0800000, 1'b0, 1'b1, 8'd255, 2, 1'b1, 24'h000000, 8'd255, 0, 0, 1, 0);
        runOp("neg_one",      25'h1FFFFFF, 1'b1, 1'b0, 8'd30, 26, 1'b1, 24'h800000, 8'd7,   0, 0, 0, 0);
        runOp("zero",         25'h0000000, 1'b1, 1'b1, 8'd90,  2, 1'b0, 24'h000000, 8'd0,   1, 0, 0, 0);
        runOp("underflow",    25'h0000010, 1'b1, 1'b0, 8'd3,   6, 1'b0, 24'h000080, 8'd0,   0, 1, 0, 5);
        runOp("most_neg",     25'h1000000, 1'b1, 1'b0, 8'd10,  2, 1'b1, 24'h800000, 8'd11,  0, 0, 0, 0);
`ifdef ROUND_EN
        runOp("carry_round",  25'h1FFFFFF, 1'b0, 1'b0, 8'd100, 3, 1'b0, 24'h800000, 8'd102, 0, 0, 0, 0);
`else
        runOp("carry_trunc",  25'h1FFFFFF, 1'b0, 1'b0, 8'd100, 2, 1'b0, 24'hFFFFFF, 8'd101, 0, 0, 0, 0);
`endif

        // Reset in the middle of a long normalization must abandon it at once.
        @(negedge clk);
        bus.sumIn      = 25'h1FFFFFF;
        bus.subtract   = 1'b1;
        bus.signIn     = 1'b0;
        bus.exponentIn = 8'd30;
        bus.inValid    = 1'b1;
        @(posedge clk);
        #1;
        bus.inValid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("mid-norm busy inReady", 32'(bus.inReady), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid-norm reset outValid/inReady", 32'({bus.outValid, bus.inReady}), 32'b01);
        check("mid-norm reset fields",
              32'({bus.signOut, bus.mantissaOut, bus.exponentOut}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("op reset_mid_norm: outValid=%0d inReady=%0d", bus.outValid, bus.inReady);

        runOp("after_reset",  25'h0400000, 1'b0, 1'b0, 8'd50,  4, 1'b0, 24'h800000, 8'd49,  0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
